alu_iter: RTL and testbench
===========================

# alu_iter

Parametrised, multi-cycle successor to the 8-bit combinational ALU. It performs the same 8051-style opcode set on W-bit operands. MUL and DIV are iterative shift-add and restoring-divide engines, with the high product or remainder returned on a second result port. Full PSW flag generation is included. Operations are accepted and returned over valid/ready handshakes, so the block sits between instruction decode and the accumulator/B/PSW writeback.

## Interface
- W, 8, operand/result width; even, ≥ 8.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept; high only in IDLE.
- opcode  in  8  operation code: ADD 01, SUBB 02, INC 03, DEC 04, MUL 05, DIV 06, DA 07, ADC 08, AND 09, OR 0A, XOR 0B, RL 0C, RLC 0D, RR 0E, RRC 0F, CLR 10, CPL 11, SWAP 12.
- operand1  in  W  accumulator operand (A).
- operand2  in  W  second operand / divisor / multiplier (B).
- in_psw  in  8  incoming PSW {CY,AC,F0,RS1,RS0,OV,UD,P}.
- out_valid  out  1  result held and valid.
- out_ready  in  1  consumer accepts result.
- result  out  W  primary result; quotient for DIV; low product for MUL.
- result_hi  out  W  high product for MUL; remainder for DIV; 0 for all other ops.
- out_psw  out  8  updated PSW, same bit order as in_psw.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready=1. On in_valid, register opcode, operands and in_psw.
  - Single-cycle ops go IDLE→DONE.
  - MUL/DIV go IDLE→CALC.
  - CALC: runs exactly W iterations, counted by a ceil(log2 W)-bit counter, then →DONE.
  - DONE: out_valid=1, outputs frozen. On out_ready, →IDLE.
- ADD/ADC: result = A + B (+CY for ADC).
  - CY = carry out of bit W-1.
  - AC = carry out of bit 3.
  - OV = signed overflow.
- SUBB: result = A − B − CY.
  - CY = borrow out of bit W-1.
  - AC = borrow out of bit 3.
  - OV = signed overflow.
- INC/DEC: ±1 modulo 2^W. CY/AC/OV unchanged.
- Logic ops (AND/OR/XOR/CPL/CLR): CY/AC/OV unchanged.
- Rotates:
  - RL/RR: rotate A by 1.
  - RLC/RRC: rotate through CY; the new CY is the bit shifted out.
  - SWAP: exchange the W/2-bit halves.
- MUL: {result_hi,result} = A×B, unsigned. CY=0. OV = (result_hi≠0).
- DIV: result = A/B, result_hi = A%B, unsigned. CY=0.
  - B=0: result=0, result_hi=0, OV=1; still takes W cycles.
- DA (8051 rules, applied to bits [7:0]; bits above 7 pass through):
  - If low nibble >9 or AC=1, add 06h.
  - Then, if high nibble >9 or CY=1 or the first step carried out, add 60h and set CY=1.
  - Otherwise CY is unchanged.
  - AC and OV are unchanged.
- Unknown opcode: result = A, flags pass through except P.
- F0, RS1, RS0, UD always pass through from the captured in_psw.
- P = XOR of all result bits (1 = odd count), recomputed every op.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, result_hi=0, out_psw=00h.
- Latency from the in_valid&in_ready edge to out_valid high:
  - Single-cycle ops: 1 cycle.
  - MUL/DIV: W+1 cycles (8-bit MUL/DIV: 9 cycles).
- Accept at most one op per IDLE visit. in_ready is low in CALC and DONE; there is no same-cycle accept while leaving DONE.
- Minimum issue interval:
  - 2 cycles per single-cycle op when out_ready is held high.
  - W+2 cycles per MUL/DIV.
- Backpressure: while out_ready=0 in DONE, result, result_hi and out_psw hold stable.
- Input changes after acceptance do not affect the op in flight.
- Reset asserted in any state (including mid-CALC) aborts the op. Reset values appear on the next edge, and no out_valid is produced for the aborted op.

## Test plan
- ADD A=7Fh, B=01h, CY=0 → result 80h, CY0 AC1 OV1 P1. out_valid one cycle after accept.
- SUBB A=10h, B=20h, CY=1 → result EFh, CY1 AC1 OV0 P1.
- MUL A=80h, B=03h → result 80h, result_hi 01h, OV1 CY0. out_valid exactly 9 cycles after accept.
- DIV A=FBh, B=12h → result 0Dh, result_hi 11h, OV0. Then DIV B=00h → result 00h, result_hi 00h, OV1.
- ADD 49h+38h (gives 81h, AC1), then DA with the returned PSW → 87h, CY0. Also DA on A=9Ah, AC0, CY0 → 00h, CY1.
- Hold out_ready=0 for 5 cycles after a RLC (A=81h, CY0 → 02h, CY1); outputs stable and in_ready low throughout. Separately, assert reset 4 cycles into a MUL → IDLE and all outputs zero next cycle, no out_valid.

Source files
------------

// File: rtl/alu_iter_if.sv
// Handshake bundle between instruction decode, the iterative ALU and the
// accumulator/B/PSW writeback stage.
interface alu_iter_if #(parameter int W = 8);
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   opcode;
  logic [W-1:0] operand1;
  logic [W-1:0] operand2;
  logic [7:0]   in_psw;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic [7:0]   out_psw;

  modport master (
    output in_valid, opcode, operand1, operand2, in_psw, out_ready,
    input  in_ready, out_valid, result, result_hi, out_psw
  );

  modport slave (
    input  in_valid, opcode, operand1, operand2, in_psw, out_ready,
    output in_ready, out_valid, result, result_hi, out_psw
  );
endinterface

// File: rtl/alu_iter.sv
// Multi-cycle 8051-style ALU: single-cycle arithmetic/logic/rotate ops plus
// iterative shift-add MUL and restoring DIV, with PSW flag generation.
//
// state | meaning
// IDLE  | ready for an op; single-cycle results are registered on accept
// CALC  | MUL/DIV engine running, one iteration per cycle
// DONE  | result held valid until the consumer takes it
module alu_iter #(
  parameter int W = 8
) (
  input logic      clk,
  input logic      reset,
  alu_iter_if.slave bus
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LOAD = CW'(W - 1);

  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUBB = 8'h02;
  localparam logic [7:0] OP_INC  = 8'h03;
  localparam logic [7:0] OP_DEC  = 8'h04;
  localparam logic [7:0] OP_MUL  = 8'h05;
  localparam logic [7:0] OP_DIV  = 8'h06;
  localparam logic [7:0] OP_DA   = 8'h07;
  localparam logic [7:0] OP_ADC  = 8'h08;
  localparam logic [7:0] OP_AND  = 8'h09;
  localparam logic [7:0] OP_OR   = 8'h0A;
  localparam logic [7:0] OP_XOR  = 8'h0B;
  localparam logic [7:0] OP_RL   = 8'h0C;
  localparam logic [7:0] OP_RLC  = 8'h0D;
  localparam logic [7:0] OP_RR   = 8'h0E;
  localparam logic [7:0] OP_RRC  = 8'h0F;
  localparam logic [7:0] OP_CLR  = 8'h10;
  localparam logic [7:0] OP_CPL  = 8'h11;
  localparam logic [7:0] OP_SWAP = 8'h12;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nx;

  logic [W-1:0]  work_hi, work_lo, work_b;
  logic [CW-1:0] cnt;
  logic          mul_q;
  logic          b_zero_q;
  logic [4:0]    psw_keep_q;
  logic [W-1:0]  res_q, res_hi_q;
  logic [7:0]    psw_out_q;

  logic [W-1:0] op_a, op_b;
  logic         cy_in, ac_in, ov_in;
  logic         is_multi;
  logic         adc_in;
  logic [W:0]   add_w, sub_w;
  logic         da_step1, da_step2;
  logic [8:0]   da_t;
  logic [7:0]   da_v;
  logic [W-1:0] sc_res;
  logic         sc_cy, sc_ac, sc_ov;
  logic [7:0]   sc_psw;

  logic [W:0]   mul_sum;
  logic [W-1:0] mul_hi_nx, mul_lo_nx;
  logic [W:0]   div_shift;
  logic         div_ge;
  logic [W-1:0] rem_sub, rem_nx, quo_nx;
  logic [W-1:0] res_fin, hi_fin;
  logic         ov_fin;
  logic [7:0]   psw_fin;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = is_multi ? CALC : DONE;
      end
      CALC: begin
        if (cnt == '0) state_nx = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- single-cycle datapath ----------------
  assign op_a     = bus.operand1;
  assign op_b     = bus.operand2;
  assign cy_in    = bus.in_psw[7];
  assign ac_in    = bus.in_psw[6];
  assign ov_in    = bus.in_psw[2];
  assign is_multi = (bus.opcode == OP_MUL) || (bus.opcode == OP_DIV);
  assign adc_in   = (bus.opcode == OP_ADC) && cy_in;

  assign add_w = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, adc_in};
  assign sub_w = {1'b0, op_a} - {1'b0, op_b} - {{W{1'b0}}, cy_in};

  // Decimal adjust works only on the low byte; wider operands pass bits above 7.
  assign da_step1 = (op_a[3:0] > 4'd9) || ac_in;
  assign da_t     = {1'b0, op_a[7:0]} + (da_step1 ? 9'h006 : 9'h000);
  assign da_step2 = (da_t[7:4] > 4'd9) || cy_in || da_t[8];
  assign da_v     = da_t[7:0] + (da_step2 ? 8'h60 : 8'h00);

  always_comb begin
    sc_res = op_a;
    sc_cy  = cy_in;
    sc_ac  = ac_in;
    sc_ov  = ov_in;
    case (bus.opcode)
      OP_ADD, OP_ADC: begin
        sc_res = add_w[W-1:0];
        sc_cy  = add_w[W];
        sc_ac  = op_a[4] ^ op_b[4] ^ add_w[4];
        sc_ov  = (op_a[W-1] == op_b[W-1]) && (add_w[W-1] != op_a[W-1]);
      end
      OP_SUBB: begin
        sc_res = sub_w[W-1:0];
        sc_cy  = sub_w[W];
        sc_ac  = op_a[4] ^ op_b[4] ^ sub_w[4];
        sc_ov  = (op_a[W-1] != op_b[W-1]) && (sub_w[W-1] != op_a[W-1]);
      end
      OP_INC:  sc_res = op_a + W'(1);
      OP_DEC:  sc_res = op_a - W'(1);
      OP_DA: begin
        sc_res[7:0] = da_v;
        if (da_step2) sc_cy = 1'b1;
      end
      OP_AND:  sc_res = op_a & op_b;
      OP_OR:   sc_res = op_a | op_b;
      OP_XOR:  sc_res = op_a ^ op_b;
      OP_RL:   sc_res = {op_a[W-2:0], op_a[W-1]};
      OP_RLC: begin
        sc_res = {op_a[W-2:0], cy_in};
        sc_cy  = op_a[W-1];
      end
      OP_RR:   sc_res = {op_a[0], op_a[W-1:1]};
      OP_RRC: begin
        sc_res = {cy_in, op_a[W-1:1]};
        sc_cy  = op_a[0];
      end
      OP_CLR:  sc_res = '0;
      OP_CPL:  sc_res = ~op_a;
      OP_SWAP: sc_res = {op_a[W/2-1:0], op_a[W-1:W/2]};
      default: ;
    endcase
    sc_psw = {sc_cy, sc_ac, bus.in_psw[5:3], sc_ov, bus.in_psw[1], ^sc_res};
  end

  // ---------------- iterative MUL / DIV ----------------
  // MUL: work_lo holds the multiplier and fills with product bits from the top.
  assign mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, work_b} : '0);
  assign mul_hi_nx = mul_sum[W:1];
  assign mul_lo_nx = {mul_sum[0], work_lo[W-1:1]};

  // DIV: partial remainder is always below the divisor, so the difference fits W bits.
  assign div_shift = {work_hi, work_lo[W-1]};
  assign div_ge    = div_shift >= {1'b0, work_b};
  assign rem_sub   = div_shift[W-1:0] - work_b;
  assign rem_nx    = div_ge ? rem_sub : div_shift[W-1:0];
  assign quo_nx    = {work_lo[W-2:0], div_ge};

  assign res_fin = mul_q ? mul_lo_nx : (b_zero_q ? '0 : quo_nx);
  assign hi_fin  = mul_q ? mul_hi_nx : (b_zero_q ? '0 : rem_nx);
  assign ov_fin  = mul_q ? (|mul_hi_nx) : b_zero_q;
  assign psw_fin = {1'b0, psw_keep_q[4:1], ov_fin, psw_keep_q[0], ^res_fin};

  always_ff @(posedge clk) begin
    if (reset) begin
      work_hi    <= '0;
      work_lo    <= '0;
      work_b     <= '0;
      cnt        <= '0;
      mul_q      <= 1'b0;
      b_zero_q   <= 1'b0;
      psw_keep_q <= '0;
      res_q      <= '0;
      res_hi_q   <= '0;
      psw_out_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (is_multi) begin
              mul_q      <= (bus.opcode == OP_MUL);
              b_zero_q   <= (op_b == '0);
              psw_keep_q <= {bus.in_psw[6:3], bus.in_psw[1]};
              work_hi    <= '0;
              work_lo    <= (bus.opcode == OP_MUL) ? op_b : op_a;
              work_b     <= (bus.opcode == OP_MUL) ? op_a : op_b;
              cnt        <= CNT_LOAD;
            end else begin
              res_q     <= sc_res;
              res_hi_q  <= '0;
              psw_out_q <= sc_psw;
            end
          end
        end
        CALC: begin
          work_hi <= mul_q ? mul_hi_nx : rem_nx;
          work_lo <= mul_q ? mul_lo_nx : quo_nx;
          cnt     <= cnt - CW'(1);
          if (cnt == '0) begin
            res_q     <= res_fin;
            res_hi_q  <= hi_fin;
            psw_out_q <= psw_fin;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result    = res_q;
  assign bus.result_hi = res_hi_q;
  assign bus.out_psw   = psw_out_q;

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter (W=8): hand-computed vectors for every opcode
// class, MUL/DIV latency, backpressure hold and reset abort.
module tb_alu_iter;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  alu_iter_if #(.W(8)) bus ();

  alu_iter #(.W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Offer an op, wait for acceptance, scramble inputs, then wait for out_valid.
  task automatic run_op(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] psw, output int lat);
    int guard;
    bus.opcode   = op;
    bus.operand1 = a;
    bus.operand2 = b;
    bus.in_psw   = psw;
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.opcode   = 8'h00;
    bus.operand1 = ~a;
    bus.operand2 = ~b;
    bus.in_psw   = ~psw;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic sc_case(input string tag, input logic [7:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] psw,
                         input logic [7:0] exp_res, input logic [7:0] exp_psw);
    int lat;
    run_op(op, a, b, psw, lat);
    check_val({tag, "_lat"}, 16'(lat), 16'd1);
    check_val({tag, "_res"}, 16'(bus.result), 16'(exp_res));
    check_val({tag, "_hi"},  16'(bus.result_hi), 16'h0);
    check_val({tag, "_psw"}, 16'(bus.out_psw), 16'(exp_psw));
    retire();
  endtask

  initial begin
    int lat;
    int seen;
    n_cmp = 0;
    n_bad = 0;
    bus.in_valid  = 1'b0;
    bus.opcode    = 8'h00;
    bus.operand1  = 8'h00;
    bus.operand2  = 8'h00;
    bus.in_psw    = 8'h00;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check_val("rst_in_ready",  16'(bus.in_ready), 16'd1);
    check_val("rst_out_valid", 16'(bus.out_valid), 16'd0);
    check_val("rst_result",    16'(bus.result), 16'h0);
    check_val("rst_result_hi", 16'(bus.result_hi), 16'h0);
    check_val("rst_psw",       16'(bus.out_psw), 16'h0);

    // ADD 7F+01 with F0/RS1/RS0 set to confirm pass-through
    sc_case("add",  8'h01, 8'h7F, 8'h01, 8'h38, 8'h80, 8'h7D);
    sc_case("subb", 8'h02, 8'h10, 8'h20, 8'h80, 8'hEF, 8'hC1);

    run_op(8'h05, 8'h80, 8'h03, 8'h00, lat);
    check_val("mul_lat", 16'(lat), 16'd9);
    check_val("mul_res", 16'(bus.result), 16'h80);
    check_val("mul_hi",  16'(bus.result_hi), 16'h01);
    check_val("mul_cy",  16'(bus.out_psw[7]), 16'd0);
    check_val("mul_ov",  16'(bus.out_psw[2]), 16'd1);
    retire();

    run_op(8'h06, 8'hFB, 8'h12, 8'h80, lat);
    check_val("div_lat", 16'(lat), 16'd9);
    check_val("div_res", 16'(bus.result), 16'h0D);
    check_val("div_hi",  16'(bus.result_hi), 16'h11);
    check_val("div_cy",  16'(bus.out_psw[7]), 16'd0);
    check_val("div_ov",  16'(bus.out_psw[2]), 16'd0);
    retire();

    run_op(8'h06, 8'hFB, 8'h00, 8'h00, lat);
    check_val("div0_lat", 16'(lat), 16'd9);
    check_val("div0_res", 16'(bus.result), 16'h00);
    check_val("div0_hi",  16'(bus.result_hi), 16'h00);
    check_val("div0_ov",  16'(bus.out_psw[2]), 16'd1);
    retire();

    sc_case("add_bcd", 8'h01, 8'h49, 8'h38, 8'h00, 8'h81, 8'h44);
    sc_case("da_ac",   8'h07, 8'h81, 8'h00, 8'h44, 8'h87, 8'h44);
    sc_case("da_hi",   8'h07, 8'h9A, 8'h00, 8'h00, 8'h00, 8'h80);
    sc_case("inc",     8'h03, 8'hFF, 8'h00, 8'h80, 8'h00, 8'h80);
    sc_case("dec",     8'h04, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00);
    sc_case("and",     8'h09, 8'h0F, 8'h07, 8'h00, 8'h07, 8'h01);
    sc_case("or",      8'h0A, 8'h50, 8'h0A, 8'h44, 8'h5A, 8'h44);
    sc_case("xor",     8'h0B, 8'hFF, 8'h0F, 8'h00, 8'hF0, 8'h00);
    sc_case("cpl",     8'h11, 8'h55, 8'h00, 8'h00, 8'hAA, 8'h00);
    sc_case("clr",     8'h10, 8'hFF, 8'h00, 8'hC4, 8'h00, 8'hC4);
    sc_case("rl",      8'h0C, 8'h81, 8'h00, 8'h00, 8'h03, 8'h00);
    sc_case("rr",      8'h0E, 8'h01, 8'h00, 8'h00, 8'h80, 8'h01);
    sc_case("rrc",     8'h0F, 8'h01, 8'h00, 8'h00, 8'h00, 8'h80);
    sc_case("swap",    8'h12, 8'h5A, 8'h00, 8'h00, 8'hA5, 8'h00);
    sc_case("adc",     8'h08, 8'hFF, 8'h00, 8'h80, 8'h00, 8'hC0);
    sc_case("unknown", 8'h20, 8'h07, 8'h00, 8'hC4, 8'h07, 8'hC5);

    // RLC under backpressure: DONE must hold everything for 5 cycles
    run_op(8'h0D, 8'h81, 8'h00, 8'h00, lat);
    check_val("rlc_lat", 16'(lat), 16'd1);
    for (int i = 0; i < 5; i++) begin
      check_val("hold_res",      16'(bus.result), 16'h02);
      check_val("hold_psw",      16'(bus.out_psw), 16'h81);
      check_val("hold_hi",       16'(bus.result_hi), 16'h00);
      check_val("hold_in_ready", 16'(bus.in_ready), 16'd0);
      check_val("hold_valid",    16'(bus.out_valid), 16'd1);
      @(posedge clk); #1;
    end
    retire();
    check_val("post_hold_in_ready", 16'(bus.in_ready), 16'd1);
    check_val("post_hold_valid",    16'(bus.out_valid), 16'd0);

    // Reset four cycles into a MUL aborts it
    bus.opcode   = 8'h05;
    bus.operand1 = 8'hFF;
    bus.operand2 = 8'hFF;
    bus.in_psw   = 8'h00;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_val("abort_busy", 16'(bus.in_ready), 16'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_val("abort_in_ready",  16'(bus.in_ready), 16'd1);
    check_val("abort_out_valid", 16'(bus.out_valid), 16'd0);
    check_val("abort_result",    16'(bus.result), 16'h0);
    check_val("abort_result_hi", 16'(bus.result_hi), 16'h0);
    check_val("abort_psw",       16'(bus.out_psw), 16'h0);
    bus.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.out_valid) seen++;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    check_val("abort_no_valid", 16'(seen), 16'd0);

    sc_case("after_abort", 8'h03, 8'h41, 8'h00, 8'h00, 8'h42, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
